// File: rtl/wormhole_arbiter.sv
// Round-robin wormhole arbiter: locks one input onto the output for a whole packet (head + body flits).
// Grant appears 1 cycle after a request is sampled in IDLE; ready_i/flit_valid_i low stall the packet with all state held.
module wormhole_arbiter #(
   parameter int NUM_PORTS = 5,
   parameter int ADD_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_PORTS-1:0]           req_i,
   input  logic [NUM_PORTS*ADD_WIDTH-1:0] flit_length_i,
   input  logic [NUM_PORTS-1:0]           flit_valid_i,
   input  logic                           ready_i,
   output logic [NUM_PORTS-1:0]           grant_o,
   output logic                           busy_o,
   output logic                           last_o,
   output logic [ADD_WIDTH:0]             remaining_o
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [ADD_WIDTH:0]   rem_q, rem_d;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     cand;
   int                   cand_int;
   logic                 win_found;
   logic                 xfer;
   logic                 last;

   // Search upward from the pointer, wrapping, and keep the first requester found.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_int  = 0;
      cand      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand_int = int'(ptr_q) + k;
         if (cand_int >= NUM_PORTS) begin
            cand_int = cand_int - NUM_PORTS;
         end
         cand = IDX_W'(cand_int);
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign xfer = (state_q == LOCKED) && flit_valid_i[owner_q] && ready_i;
   assign last = (state_q == LOCKED) && (rem_q == (ADD_WIDTH+1)'(1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = LOCKED;
               grant_d = NUM_PORTS'(1) << win_idx;
               owner_d = win_idx;
               rem_d   = {1'b0, flit_length_i[int'(win_idx)*ADD_WIDTH +: ADD_WIDTH]}
                         + (ADD_WIDTH+1)'(1);
            end
         end
         LOCKED: begin
            // Requests are ignored here; only transfers move the packet along.
            if (xfer) begin
               if (last) begin
                  state_d = IDLE;
                  grant_d = '0;
                  rem_d   = '0;
                  ptr_d   = (owner_q == IDX_W'(NUM_PORTS-1)) ? '0 : owner_q + IDX_W'(1);
               end else begin
                  rem_d = rem_q - (ADD_WIDTH+1)'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
      end
   end

   assign grant_o     = grant_q;
   assign busy_o      = (state_q == LOCKED);
   assign last_o      = last;
   assign remaining_o = rem_q;

endmodule

// File: tb/tb_wormhole_arbiter.sv
// Bench for wormhole_arbiter: directed scenarios plus a randomized run against a packet-level reference model.
module tb_wormhole_arbiter;

   localparam int N  = 5;
   localparam int AW = 8;
   localparam int VW = N + AW + 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] flen;
   logic [N-1:0]    fvalid;
   logic            ready;
   logic [N-1:0]    grant;
   logic            busy;
   logic            last;
   logic [AW:0]     remaining;
   logic [VW-1:0]   dut_vec;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: owner (-1 = nobody), flits left in the packet, round-robin pointer.
   int m_owner;
   int m_rem;
   int m_ptr;

   always #5 clk = ~clk;

   wormhole_arbiter #(.NUM_PORTS(N), .ADD_WIDTH(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_i         (req),
      .flit_length_i (flen),
      .flit_valid_i  (fvalid),
      .ready_i       (ready),
      .grant_o       (grant),
      .busy_o        (busy),
      .last_o        (last),
      .remaining_o   (remaining)
   );

   assign dut_vec = {grant, busy, last, remaining};

   function automatic logic [VW-1:0] exp_vec();
      logic [N-1:0] g;
      g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      return {g, (m_owner >= 0), (m_owner >= 0) && (m_rem == 1), (AW+1)'(m_rem)};
   endfunction

   task automatic m_clear();
      m_owner = -1;
      m_rem   = 0;
      m_ptr   = 0;
   endtask

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic tick();
      int o, r, p;
      o = m_owner; r = m_rem; p = m_ptr;
      if (reset) begin
         o = -1; r = 0; p = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req[c]) begin
               o = c;
               r = int'(flen[c*AW +: AW]) + 1;
               break;
            end
         end
      end else if (fvalid[m_owner] && ready) begin
         if (m_rem == 1) begin
            o = -1; r = 0; p = (m_owner + 1) % N;
         end else begin
            r = m_rem - 1;
         end
      end
      @(posedge clk);
      #1;
      m_owner = o; m_rem = r; m_ptr = p;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      m_clear();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; flen = '0; fvalid = '0; ready = 1'b0;
      m_clear();
      tick();
      tick();
      tests_run++;
      if (dut_vec !== VW'(0)) begin
         tests_failed++;
         $display("FAIL reset_state: got %h expected %h", dut_vec, VW'(0));
      end
      reset = 1'b0;
   endtask

   task automatic test_single_packet();
      req = 5'b00100; flen = '0; flen[2*AW +: AW] = 8'd3; fvalid = '1; ready = 1'b1;
      tick();
      req = '0;
      tests_run++;
      if ({grant, remaining} !== {5'b00100, 9'd4}) begin
         tests_failed++;
         $display("FAIL single_grant: got %b/%0d expected 00100/4", grant, remaining);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({busy, last, remaining} !== {1'b1, (i == 3), 9'(4 - i)}) begin
            tests_failed++;
            $display("FAIL single_count[%0d]: got busy=%b last=%b rem=%0d expected rem=%0d",
                     i, busy, last, remaining, 4 - i);
         end
         tick();
      end
      tests_run++;
      if ({grant, busy} !== 6'b0) begin
         tests_failed++;
         $display("FAIL single_release: got grant=%b busy=%b expected 0", grant, busy);
      end
      req = '1; flen = '0;
      tick();
      req = '0;
      tests_run++;
      if (grant !== 5'b01000) begin
         tests_failed++;
         $display("FAIL single_pointer: got %b expected 01000", grant);
      end
      tick();
   endtask

   task automatic test_round_robin();
      reset_pulse();
      req = '1; flen = '0; fvalid = '1; ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         tests_run++;
         if (grant !== (N'(1) << (k % N))) begin
            tests_failed++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant, N'(1) << (k % N));
         end
         tick();
         tests_run++;
         if (grant !== '0) begin
            tests_failed++;
            $display("FAIL rr_idle_gap[%0d]: got %b expected 00000", k, grant);
         end
      end
      req = '0;
   endtask

   task automatic test_stall();
      req = 5'b00010; flen = '0; flen[1*AW +: AW] = 8'd2; fvalid = '1; ready = 1'b1;
      tick();
      req = '0;
      tests_run++;
      if ({grant, remaining} !== {5'b00010, 9'd3}) begin
         tests_failed++;
         $display("FAIL stall_grant: got %b/%0d expected 00010/3", grant, remaining);
      end
      tick();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests_run++;
         if ({grant, remaining} !== {5'b00010, 9'd2}) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: got %b/%0d expected 00010/2", i, grant, remaining);
         end
      end
      ready = 1'b1;
      tick();
      tests_run++;
      if ({last, remaining} !== {1'b1, 9'd1}) begin
         tests_failed++;
         $display("FAIL stall_last: got last=%b rem=%0d expected 1/1", last, remaining);
      end
      tick();
      tests_run++;
      if (grant !== '0) begin
         tests_failed++;
         $display("FAIL stall_release: got %b expected 00000", grant);
      end
   endtask

   task automatic test_lock();
      req = 5'b01000; flen = '0; flen[3*AW +: AW] = 8'd4; fvalid = '1; ready = 1'b1;
      tick();
      req = 5'b00001;
      fvalid = 5'b10111;
      tick();
      tick();
      tests_run++;
      if ({grant, remaining} !== {5'b01000, 9'd5}) begin
         tests_failed++;
         $display("FAIL lock_foreign_valid: got %b/%0d expected 01000/5", grant, remaining);
      end
      fvalid = '1;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (grant !== 5'b01000) begin
            tests_failed++;
            $display("FAIL lock_hold[%0d]: got %b expected 01000", i, grant);
         end
         tick();
      end
      tests_run++;
      if (grant !== '0) begin
         tests_failed++;
         $display("FAIL lock_release: got %b expected 00000", grant);
      end
      tick();
      req = '0;
      tests_run++;
      if (grant !== 5'b00001) begin
         tests_failed++;
         $display("FAIL lock_next_grant: got %b expected 00001", grant);
      end
      tick();
   endtask

   task automatic test_max_length();
      int count, cycles;
      req = 5'b10000; flen = '0; flen[4*AW +: AW] = 8'hFF; fvalid = '1; ready = 1'b1;
      tick();
      req = '0;
      tests_run++;
      if (remaining !== 9'd256) begin
         tests_failed++;
         $display("FAIL max_len_load: got %0d expected 256", remaining);
      end
      count = 0; cycles = 0;
      while (busy && cycles < 2000) begin
         ready = ($urandom % 2) == 0;
         if (ready) count++;
         tick();
         cycles++;
      end
      ready = 1'b1;
      tests_run++;
      if (busy !== 1'b0 || count != 256) begin
         tests_failed++;
         $display("FAIL max_len_transfers: got %0d (busy=%b) expected 256", count, busy);
      end
   endtask

   task automatic test_async_reset();
      req = 5'b00001; flen = '0; flen[0 +: AW] = 8'd2; fvalid = '1; ready = 1'b0;
      tick();
      req = '0;
      tests_run++;
      if ({grant, remaining} !== {5'b00001, 9'd3}) begin
         tests_failed++;
         $display("FAIL areset_setup: got %b/%0d expected 00001/3", grant, remaining);
      end
      #3;
      reset = 1'b1;
      #1;
      tests_run++;
      if (dut_vec !== VW'(0)) begin
         tests_failed++;
         $display("FAIL areset_immediate: got %h expected %h", dut_vec, VW'(0));
      end
      m_clear();
      #2;
      reset = 1'b0;
      req = 5'b10100; ready = 1'b1;
      tick();
      req = '0;
      tests_run++;
      if (grant !== 5'b00100) begin
         tests_failed++;
         $display("FAIL areset_port0_favoured: got %b expected 00100", grant);
      end
      tick();
   endtask

   task automatic test_random();
      reset_pulse();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         req = N'($urandom);
         for (int p = 0; p < N; p++) begin
            flen[p*AW +: AW] = ($urandom % 32 == 0) ? AW'($urandom) : AW'($urandom % 4);
         end
         fvalid = N'($urandom);
         ready  = ($urandom % 4) != 0;
         tick();
         tests_run++;
         if (dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL random[%0d]: got grant/busy/last/rem %h expected %h", cyc, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_lock();
      test_max_length();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
